// File: rtl/ground_scroll_compositor_pkg.sv
// -----------------------------------------------------------------------------
// ground_scroll_compositor_pkg
//   Shared constants and types for the scrolling ground layer. The collision
//   logic also imports this package, so the band geometry and the
//   scroll-controller state encoding live here and not in the modules.
//
//   Contents:
//     TILE_SZ / TILE_W   tile edge in pixels and its log2 (the ROM's address width)
//     GROUND_Y0          first screen row of the grass band
//     V_ACTIVE           last visible row + 1
//     FILL_RGB           solid dirt colour used below the grass band {R,G,B}
//     scroll_state_t     scroll controller states (IDLE=0, RUN=1, FROZEN=2)
//     band_t             per-row classification used by the compositor
//     classify_row()     maps a screen row onto band_t
// -----------------------------------------------------------------------------
package ground_scroll_compositor_pkg;

    localparam int          TILE_SZ   = 16;
    localparam int          TILE_W    = $clog2(TILE_SZ);
    localparam int          GROUND_Y0 = 400;
    localparam int          V_ACTIVE  = 480;
    localparam logic [23:0] FILL_RGB  = 24'hDED895;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } scroll_state_t;

    // BAND_OFF covers rows at or below V_ACTIVE. They are never visible in
    // practice, and the compositor passes the background through for them.
    typedef enum logic [1:0] {
        BAND_SKY  = 2'd0,
        BAND_TILE = 2'd1,
        BAND_FILL = 2'd2,
        BAND_OFF  = 2'd3
    } band_t;

    function automatic band_t classify_row(input logic [10:0] y);
        band_t b;
        if (y < 11'(GROUND_Y0))
            b = BAND_SKY;
        else if (y < 11'(GROUND_Y0 + TILE_SZ))
            b = BAND_TILE;
        else if (y < 11'(V_ACTIVE))
            b = BAND_FILL;
        else
            b = BAND_OFF;
        return b;
    endfunction

endpackage

// File: rtl/ground_scroll_compositor_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// ground_scroll_compositor_scroll_ctrl
//   Frame-rate scroll controller. It holds the horizontal scroll offset that
//   the compositor adds to px_x. The offset only changes on frame_start or
//   restart. If frame_start falls in vertical blank, every visible pixel of a
//   frame sees the same offset.
//
//   Ports:
//     clk, rst       pixel clock, asynchronous active-high reset
//     frame_start    one-cycle pulse at the start of vertical blank
//     run            level, sampled only on frame_start
//     restart        one-cycle pulse: offset -> 0, state -> IDLE (wins over frame_start)
//     speed[2:0]     pixels added to the offset per frame
//     scroll_ofs[3:0] current offset (mod TILE_SZ)
//     scroll_state[1:0] current FSM state, for debug/checkers
//
//   Transitions, evaluated on frame_start only:
//     IDLE   + run  -> RUN, offset += speed   (the first running frame already moves)
//     RUN    + run  -> RUN, offset += speed
//     RUN    + !run -> FROZEN, offset held
//     FROZEN + run  -> RUN, offset += speed on the same pulse
//     any    + !run -> offset held (IDLE stays IDLE, FROZEN stays FROZEN)
// -----------------------------------------------------------------------------
module ground_scroll_compositor_scroll_ctrl
    import ground_scroll_compositor_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              run,
    input  logic              restart,
    input  logic [2:0]        speed,
    output logic [TILE_W-1:0] scroll_ofs,
    output logic [1:0]        scroll_state
);

    scroll_state_t     state;
    logic [TILE_W-1:0] ofs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            ofs   <= '0;
        end else if (restart) begin
            // restart is checked before frame_start, so it also overrides a
            // frame_start in the same cycle.
            state <= ST_IDLE;
            ofs   <= '0;
        end else if (frame_start) begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state <= ST_RUN;
                        ofs   <= ofs + TILE_W'(speed);
                    end
                end
                ST_RUN: begin
                    if (run)
                        ofs <= ofs + TILE_W'(speed);
                    else
                        state <= ST_FROZEN;
                end
                ST_FROZEN: begin
                    if (run) begin
                        state <= ST_RUN;
                        ofs   <= ofs + TILE_W'(speed);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ofs   <= '0;
                end
            endcase
        end
    end

    assign scroll_ofs   = ofs;
    assign scroll_state = state;

endmodule

// File: rtl/ground_scroll_compositor.sv
// -----------------------------------------------------------------------------
// ground_scroll_compositor
//   Sits between the VGA timing/background stage and the final colour mux. It
//   drives the external 16x16 ground-tile ROM with tile-local coordinates and
//   composites the ROM's colour and mask over the background pixel stream.
//
//   Ports:
//     clk, rst              pixel clock, asynchronous active-high reset
//     px_x, px_y, px_valid  incoming pixel coordinate and its valid flag
//     bg_r/g/b              background colour of the incoming pixel
//     frame_start, run,
//     restart, speed        scroll control (see scroll_ctrl)
//     tile_ix, tile_iy      ROM column/row; only the low 4 bits are ever nonzero
//     tile_r/g/b, tile_mask ROM colour and opacity for {latched row, tile_ix}
//     o_r/g/b, o_valid      composited pixel, exactly 3 cycles after px_valid
//     scroll_ofs            current horizontal scroll offset
//     scroll_state          scroll controller state (IDLE=0, RUN=1, FROZEN=2)
//
//   Pipeline for a pixel presented in cycle t:
//     end t   : tile_iy and stage-1 registers (ix, band, bg, valid)
//     t+1     : the ROM registers the row from tile_iy
//     end t+1 : tile_ix and stage-2 registers
//     t+2     : the ROM colour is valid, and the compose mux is evaluated
//     end t+2 : o_* registered, so the pixel is visible in t+3
//   tile_iy leads tile_ix by one stage because the ROM needs one cycle for its
//   row register. With this skew the row and column for the same pixel meet
//   in t+2. The pipeline has no stall path.
// -----------------------------------------------------------------------------
module ground_scroll_compositor
    import ground_scroll_compositor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] px_x,
    input  logic [10:0] px_y,
    input  logic        px_valid,
    input  logic [7:0]  bg_r,
    input  logic [7:0]  bg_g,
    input  logic [7:0]  bg_b,
    input  logic        frame_start,
    input  logic        run,
    input  logic        restart,
    input  logic [2:0]  speed,
    output logic [10:0] tile_ix,
    output logic [10:0] tile_iy,
    input  logic [7:0]  tile_r,
    input  logic [7:0]  tile_g,
    input  logic [7:0]  tile_b,
    input  logic        tile_mask,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic        o_valid,
    output logic [3:0]  scroll_ofs,
    output logic [1:0]  scroll_state
);

    // ---------------------------------------------------------------- scroll
    logic [TILE_W-1:0] ofs;

    ground_scroll_compositor_scroll_ctrl u_scroll_ctrl (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .run          (run),
        .restart      (restart),
        .speed        (speed),
        .scroll_ofs   (ofs),
        .scroll_state (scroll_state)
    );

    assign scroll_ofs = ofs;

    // ------------------------------------------------- stage 0 (combinational)
    // Tile coordinates wrap by plain truncation to TILE_W bits. TILE_SZ is a
    // power of two, so "mod 16" costs no logic.
    logic [10:0]       dy;
    logic [TILE_W-1:0] px_ix;
    logic [TILE_W-1:0] px_iy;
    band_t             px_band;
    logic              px_in_tile;

    always_comb begin
        dy         = px_y - 11'(GROUND_Y0);
        px_ix      = px_x[TILE_W-1:0] + ofs;
        px_iy      = dy[TILE_W-1:0];
        px_band    = classify_row(px_y);
        px_in_tile = px_valid && (px_band == BAND_TILE);
    end

    // Only the low TILE_W bits of the column and row offset reach the ROM.
    logic unused_bits;
    assign unused_bits = ^{px_x[10:TILE_W], dy[10:TILE_W]};

    // -------------------------------------------------------------- stage 1
    // The ROM address is zero for pixels outside the grass band and for
    // invalid cycles. The ROM then sees a stable address whenever its output
    // is not used.
    logic [TILE_W-1:0] iy_q;
    logic [TILE_W-1:0] s1_ix;
    band_t             s1_band;
    logic [23:0]       s1_bg;
    logic              s1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iy_q     <= '0;
            s1_ix    <= '0;
            s1_band  <= BAND_SKY;
            s1_bg    <= '0;
            s1_valid <= 1'b0;
        end else begin
            iy_q     <= px_in_tile ? px_iy : '0;
            s1_ix    <= px_in_tile ? px_ix : '0;
            s1_band  <= px_band;
            s1_bg    <= {bg_r, bg_g, bg_b};
            s1_valid <= px_valid;
        end
    end

    // -------------------------------------------------------------- stage 2
    logic [TILE_W-1:0] ix_q;
    band_t             s2_band;
    logic [23:0]       s2_bg;
    logic              s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ix_q     <= '0;
            s2_band  <= BAND_SKY;
            s2_bg    <= '0;
            s2_valid <= 1'b0;
        end else begin
            ix_q     <= s1_ix;
            s2_band  <= s1_band;
            s2_bg    <= s1_bg;
            s2_valid <= s1_valid;
        end
    end

    assign tile_iy = {{(11-TILE_W){1'b0}}, iy_q};
    assign tile_ix = {{(11-TILE_W){1'b0}}, ix_q};

    // -------------------------------------------------------------- stage 3
    // In this cycle the ROM output belongs to the stage-2 pixel: its row was
    // latched from iy_q last cycle, and its column is ix_q now.
    logic [23:0] comp_rgb;

    always_comb begin
        comp_rgb = s2_bg;
        case (s2_band)
            BAND_TILE: comp_rgb = tile_mask ? {tile_r, tile_g, tile_b} : s2_bg;
            BAND_FILL: comp_rgb = FILL_RGB;
            default:   comp_rgb = s2_bg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_r     <= '0;
            o_g     <= '0;
            o_b     <= '0;
            o_valid <= 1'b0;
        end else if (s2_valid) begin
            o_r     <= comp_rgb[23:16];
            o_g     <= comp_rgb[15:8];
            o_b     <= comp_rgb[7:0];
            o_valid <= 1'b1;
        end else begin
            o_r     <= '0;
            o_g     <= '0;
            o_b     <= '0;
            o_valid <= 1'b0;
        end
    end

endmodule
